l2_cache_param: RTL and testbench
=================================

Name: l2_cache_param

Overview:
Parametrised single-bank L2 cache controller with integrated tag, valid, dirty, PLRU and data arrays. It serves NUM_REQ L1 requesters through a round-robin arbiter, with configurable associativity, set count and widths. Policy is write-back / write-allocate with tree-PLRU replacement and adds 32-bit hit/miss counters. It sits between the L1 instruction/data caches and main memory.

Parameters:
NUM_REQ, 2, number of L1 requesters (≥1)
WAYS, 4, associativity (power of 2, ≥2)
SETS, 512, sets (power of 2); IDX_W = log2(SETS)
ADDR_W, 28, L1-block address width (L1_W granule)
L1_W, 128, L1 transfer width in bits
LINE_W, 512, L2 line width; OFF_W = log2(LINE_W/L1_W); TAG_W = ADDR_W-IDX_W-OFF_W; MEM_AW = ADDR_W-OFF_W

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request pending, per requester
req_rw  in  NUM_REQ  0 = read, 1 = write
req_addr  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*L1_W  packed write data
req_gnt  out  NUM_REQ  one-hot 1-cycle pulse when a request is latched
req_done  out  NUM_REQ  one-hot 1-cycle pulse when a request completes
rdata  out  L1_W  read data; valid in the req_done cycle
busy  out  1  high in every state except IDLE
mem_re  out  1  memory line read request
mem_we  out  1  memory line write request
mem_addr  out  MEM_AW  line address
mem_wd  out  LINE_W  writeback data
mem_rd  in  LINE_W  refill data; valid with mem_complete_r
mem_complete_r  in  1  1-cycle pulse: read done
mem_complete_w  in  1  1-cycle pulse: write done
hit_cnt  out  32  lookups that hit, wraps modulo 2^32
miss_cnt  out  32  lookups that missed, wraps modulo 2^32

Behaviour:
- Address split: offset = addr[OFF_W-1:0], index = next IDX_W bits, tag = top TAG_W bits. Line address = addr[ADDR_W-1:OFF_W].
- Reset (synchronous, any state): state becomes IDLE. All outputs are driven 0 (req_gnt, req_done, rdata, busy, mem_re, mem_we, mem_addr, mem_wd, hit_cnt, miss_cnt). All valid, dirty and PLRU bits clear; the round-robin pointer returns to 0. An in-flight request is dropped with no req_done. Data and tag contents are not cleared.
- IDLE: if any req_valid, grant the first requester at or after the pointer (cyclic order) and pulse req_gnt. Latch its rw, addr and wdata. Set pointer = (i+1) mod NUM_REQ. Go to LOOKUP. A requester holds its request stable until req_gnt and drops req_valid the cycle after.
- LOOKUP (1 cycle): compare the tag against all valid ways of the set.
  - Hit: hit_cnt+1, go to ACCESS.
  - Miss: miss_cnt+1. Victim = lowest-index invalid way; otherwise the tree-PLRU way. If the victim is valid and dirty, go to WB; otherwise go to REFILL.
- WB: mem_we=1, mem_addr={victim_tag, index}, mem_wd = victim line, all held stable. On mem_complete_w, drop mem_we at the next edge and go to REFILL.
- REFILL: mem_re=1, mem_addr = request line address, held stable. On mem_complete_r, write mem_rd into the victim way and set tag, valid=1, dirty=0. Drop mem_re at the next edge and go to ACCESS.
- ACCESS (1 cycle):
  - Read: rdata = line word[offset] (bits [offset*L1_W +: L1_W]).
  - Write: replace that word with wdata and set dirty=1.
  - Update PLRU for the accessed way (every node points away from it). Pulse req_done[i]. Go to IDLE.
- Hit latency: req_done occurs 2 cycles after req_gnt. The next grant is possible in the cycle after req_done.
- mem_complete_r/w arriving outside REFILL/WB is ignored.
- rdata holds its value between reads.
- The PLRU tree holds WAYS-1 bits per set. Victim selection walks from the root following the bits.

Test Plan:
1. After reset, requester 0 reads addr 0x0000123 -> LOOKUP misses, mem_re with mem_addr 0x0000048; on complete_r, rdata = mem_rd[511:384]; req_done[0] pulses; miss_cnt=1, hit_cnt=0.
2. Requester 0 then reads 0x0000121 -> no mem_re; req_done[0] exactly 2 cycles after req_gnt[0]; rdata = mem_rd[255:128] from test 1; hit_cnt=1.
3. Both req_valid held high from reset, all hits -> grant order 0,1,0,1; each req_gnt is one-hot and one cycle wide.
4. Write 0x0000800 (wdata A), then read 0x0001000, 0x0001800, 0x0002000, then 0x0002800 -> WB with mem_addr 0x0000200 and mem_wd[127:0]=A, then REFILL with mem_addr 0x0000A00.
5. Fill set 0 with ways in order 0,1,2,3, re-hit way 0, then miss in set 0 -> way 2 is evicted.
6. Assert rst for one cycle during REFILL -> mem_re=0 and busy=0 next cycle, no req_done; a re-read of a previously cached line misses.

Source files
------------

// File: rtl/l2_cache_param.sv
// Parametrised single-bank L2 cache controller: write-back / write-allocate,
// tree-PLRU replacement, round-robin arbitration over NUM_REQ L1 requesters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_rw/req_addr/req_wdata  per-requester request (packed buses)
//   req_gnt, req_done             one-hot pulses: request latched / completed
//   rdata                         read data, valid in the req_done cycle, held otherwise
//   busy                          high whenever the controller is not idle
//   mem_re/mem_we/mem_addr/mem_wd line read/write request towards memory
//   mem_rd, mem_complete_r/_w     refill data and completion pulses from memory
//   hit_cnt, miss_cnt             wrapping lookup statistics
module l2_cache_param #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WAYS    = 4,
    parameter int unsigned SETS    = 512,
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned L1_W    = 128,
    parameter int unsigned LINE_W  = 512
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0]                      req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]               req_addr,
    input  logic [NUM_REQ*L1_W-1:0]                 req_wdata,
    output logic [NUM_REQ-1:0]                      req_gnt,
    output logic [NUM_REQ-1:0]                      req_done,
    output logic [L1_W-1:0]                         rdata,
    output logic                                    busy,
    output logic                                    mem_re,
    output logic                                    mem_we,
    output logic [ADDR_W-$clog2(LINE_W/L1_W)-1:0]   mem_addr,
    output logic [LINE_W-1:0]                       mem_wd,
    input  logic [LINE_W-1:0]                       mem_rd,
    input  logic                                    mem_complete_r,
    input  logic                                    mem_complete_w,
    output logic [31:0]                             hit_cnt,
    output logic [31:0]                             miss_cnt
);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned OFF_W  = $clog2(LINE_W / L1_W);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned MEM_AW = ADDR_W - OFF_W;
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned NODE_W = (WAYS > 2) ? $clog2(WAYS - 1) : 1;
    localparam int unsigned REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, ACCESS} state_t;

    state_t state, state_next;

    logic [LINE_W-1:0] data_arr  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
    logic [WAYS-1:0]   valid_arr [SETS];
    logic [WAYS-1:0]   dirty_arr [SETS];
    logic [WAYS-2:0]   plru_arr  [SETS];

    logic [REQ_W-1:0]  ptr;
    logic [REQ_W-1:0]  cur_req;
    logic              cur_rw;
    logic [ADDR_W-1:0] cur_addr;
    logic [L1_W-1:0]   cur_wdata;
    logic [WAY_W-1:0]  acc_way;

    logic [OFF_W-1:0]  cur_off;
    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic [MEM_AW-1:0] cur_line;

    logic              gnt_found_c;
    logic [REQ_W-1:0]  gnt_idx_c;
    logic              hit_c;
    logic [WAY_W-1:0]  hit_way_c;
    logic              inv_found_c;
    logic [WAY_W-1:0]  inv_way_c;
    logic [WAY_W-1:0]  victim_c;
    logic              victim_dirty_c;

    assign cur_off  = cur_addr[OFF_W-1:0];
    assign cur_idx  = cur_addr[OFF_W +: IDX_W];
    assign cur_tag  = cur_addr[ADDR_W-1 -: TAG_W];
    assign cur_line = cur_addr[ADDR_W-1:OFF_W];

    // Heap-ordered tree (node n has children 2n+1, 2n+2); bit 0 = go left.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        int unsigned n;
        n = 0;
        for (int unsigned l = 0; l < WAY_W; l++)
            n = 2 * n + 1 + 32'(bits[NODE_W'(n)]);
        return WAY_W'(n - (WAYS - 1));
    endfunction

    // Walk leaf-to-root, pointing every node on the path away from the way.
    function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] bits,
                                                    input logic [WAY_W-1:0] way);
        logic [WAYS-2:0] res;
        int unsigned     n;
        int unsigned     p;
        res = bits;
        n   = 32'(way) + WAYS - 1;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            p                = (n - 1) / 2;
            res[NODE_W'(p)]  = n[0];
            n                = p;
        end
        return res;
    endfunction

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found_c && req_valid[REQ_W'((32'(ptr) + k) % NUM_REQ)]) begin
                gnt_found_c = 1'b1;
                gnt_idx_c   = REQ_W'((32'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // Tag compare and victim choice (lowest invalid way, else PLRU).
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit_c && valid_arr[cur_idx][WAY_W'(w)]
                && tag_arr[cur_idx][WAY_W'(w)] == cur_tag) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!inv_found_c && !valid_arr[cur_idx][WAY_W'(w)]) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAY_W'(w);
            end
        end
        victim_c       = inv_found_c ? inv_way_c : plru_victim(plru_arr[cur_idx]);
        victim_dirty_c = valid_arr[cur_idx][victim_c] && dirty_arr[cur_idx][victim_c];
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_found_c) state_next = LOOKUP;
            LOOKUP:  state_next = hit_c ? ACCESS : (victim_dirty_c ? WB : REFILL);
            WB:      if (mem_complete_w) state_next = REFILL;
            REFILL:  if (mem_complete_r) state_next = ACCESS;
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, registered outputs and resettable metadata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_gnt   <= '0;
            req_done  <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            ptr       <= '0;
            cur_req   <= '0;
            cur_rw    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            acc_way   <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_arr[IDX_W'(s)] <= '0;
                dirty_arr[IDX_W'(s)] <= '0;
                plru_arr[IDX_W'(s)]  <= '0;
            end
        end else begin
            state    <= state_next;
            req_gnt  <= '0;
            req_done <= '0;
            busy     <= (state_next != IDLE);
            mem_re   <= (state_next == REFILL);
            mem_we   <= (state_next == WB);
            case (state)
                IDLE: if (gnt_found_c) begin
                    req_gnt   <= NUM_REQ'(1) << gnt_idx_c;
                    cur_req   <= gnt_idx_c;
                    cur_rw    <= req_rw[gnt_idx_c];
                    cur_addr  <= req_addr[32'(gnt_idx_c) * ADDR_W +: ADDR_W];
                    cur_wdata <= req_wdata[32'(gnt_idx_c) * L1_W +: L1_W];
                    ptr       <= (32'(gnt_idx_c) == NUM_REQ - 1) ? '0 : gnt_idx_c + 1'b1;
                end
                LOOKUP: begin
                    if (hit_c) begin
                        hit_cnt <= hit_cnt + 32'd1;
                        acc_way <= hit_way_c;
                    end else begin
                        miss_cnt <= miss_cnt + 32'd1;
                        acc_way  <= victim_c;
                        if (victim_dirty_c) begin
                            mem_addr <= {tag_arr[cur_idx][victim_c], cur_idx};
                            mem_wd   <= data_arr[cur_idx][victim_c];
                        end else begin
                            mem_addr <= cur_line;
                        end
                    end
                end
                WB: if (mem_complete_w) mem_addr <= cur_line;
                REFILL: if (mem_complete_r) begin
                    valid_arr[cur_idx][acc_way] <= 1'b1;
                    dirty_arr[cur_idx][acc_way] <= 1'b0;
                end
                ACCESS: begin
                    if (cur_rw)
                        dirty_arr[cur_idx][acc_way] <= 1'b1;
                    else
                        rdata <= data_arr[cur_idx][acc_way][32'(cur_off) * L1_W +: L1_W];
                    plru_arr[cur_idx] <= plru_update(plru_arr[cur_idx], acc_way);
                    req_done          <= NUM_REQ'(1) << cur_req;
                end
                default: ;
            endcase
        end
    end

    // Line data and tags are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == REFILL && mem_complete_r) begin
                data_arr[cur_idx][acc_way] <= mem_rd;
                tag_arr[cur_idx][acc_way]  <= cur_tag;
            end
            if (state == ACCESS && cur_rw)
                data_arr[cur_idx][acc_way][32'(cur_off) * L1_W +: L1_W] <= cur_wdata;
        end
    end
endmodule

// File: tb/tb_l2_cache_param.sv
// Testbench for l2_cache_param: directed scenarios plus randomized traffic,
// checked against a behavioural cache/memory model kept in the bench.
module tb_l2_cache_param;
    localparam int unsigned NR  = 2;
    localparam int unsigned AW  = 28;
    localparam int unsigned LW  = 128;
    localparam int unsigned LN  = 512;
    localparam int unsigned MAW = 26;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_rw;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_wdata;
    logic [NR-1:0]    req_gnt;
    logic [NR-1:0]    req_done;
    logic [LW-1:0]    rdata;
    logic             busy;
    logic             mem_re;
    logic             mem_we;
    logic [MAW-1:0]   mem_addr;
    logic [LN-1:0]    mem_wd;
    logic [LN-1:0]    mem_rd;
    logic             mem_complete_r;
    logic             mem_complete_w;
    logic [31:0]      hit_cnt;
    logic [31:0]      miss_cnt;

    l2_cache_param dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .req_done(req_done), .rdata(rdata), .busy(busy),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_complete_r(mem_complete_r), .mem_complete_w(mem_complete_w),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: 512 sets x 4 ways, tree-PLRU as halving decisions.
    logic [16:0]  m_tag   [512][4];
    bit           m_valid [512][4];
    bit           m_dirty [512][4];
    logic [511:0] m_data  [512][4];
    bit           m_plru  [512][3];
    logic [511:0] mem_img [logic [25:0]];
    logic [31:0]  m_hits;
    logic [31:0]  m_miss;
    logic [127:0] last_rd;

    function automatic logic [511:0] mem_line(input logic [25:0] la);
        logic [511:0] v;
        if (mem_img.exists(la)) return mem_img[la];
        for (int k = 0; k < 16; k++)
            v[k*32 +: 32] = 32'(la) * 32'h9E37_79B1 + 32'(k) * 32'h0100_0193;
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 512; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            for (int n = 0; n < 3; n++) m_plru[s][n] = 1'b0;
        end
        m_hits  = '0;
        m_miss  = '0;
        last_rd = '0;
    endtask

    function automatic int plru_pick(input int idx);
        int lo, hi, node, mid;
        lo = 0; hi = 4; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_plru[idx][node]) begin lo = mid; node = 2 * node + 2; end
            else begin hi = mid; node = 2 * node + 1; end
        end
        return lo;
    endfunction

    task automatic plru_touch(input int idx, input int way);
        int lo, hi, node, mid;
        lo = 0; hi = 4; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (way >= mid) begin m_plru[idx][node] = 1'b0; lo = mid; node = 2 * node + 2; end
            else begin m_plru[idx][node] = 1'b1; hi = mid; node = 2 * node + 1; end
        end
    endtask

    task automatic model_access(input logic [27:0] addr, input bit rw, input logic [127:0] wd,
                                output bit hit, output bit wb, output logic [25:0] wba,
                                output logic [511:0] wbd, output logic [127:0] rd);
        int idx, off, way;
        logic [16:0] tg;
        idx = int'(addr[10:2]); off = int'(addr[1:0]); tg = addr[27:11];
        hit = 1'b0; wb = 1'b0; wba = '0; wbd = '0; rd = '0; way = -1;
        for (int w = 0; w < 4; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) way = w;
        if (way >= 0) begin
            hit = 1'b1;
            m_hits++;
        end else begin
            m_miss++;
            for (int w = 3; w >= 0; w--) if (!m_valid[idx][w]) way = w;
            if (way < 0) way = plru_pick(idx);
            if (m_valid[idx][way] && m_dirty[idx][way]) begin
                wb  = 1'b1;
                wba = {m_tag[idx][way], 9'(idx)};
                wbd = m_data[idx][way];
                mem_img[wba] = wbd;
            end
            m_data[idx][way]  = mem_line(addr[27:2]);
            m_tag[idx][way]   = tg;
            m_valid[idx][way] = 1'b1;
            m_dirty[idx][way] = 1'b0;
        end
        if (rw) begin
            m_data[idx][way][off*128 +: 128] = wd;
            m_dirty[idx][way] = 1'b1;
        end else begin
            rd = m_data[idx][way][off*128 +: 128];
        end
        plru_touch(idx, way);
    endtask

    // One request from requester r, serving memory with random latency.
    task automatic txn(input int r, input bit rw, input logic [27:0] addr, input logic [127:0] wd);
        bit           e_hit, e_wb, got, done, saw_we, saw_re;
        logic [25:0]  e_wba;
        logic [511:0] e_wbd;
        logic [127:0] e_rd;
        int           cyc, dly;
        model_access(addr, rw, wd, e_hit, e_wb, e_wba, e_wbd, e_rd);
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_rw[r]    = rw;
        req_addr[r*AW +: AW]  = addr;
        req_wdata[r*LW +: LW] = wd;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk); cyc++;
            if (req_gnt != '0) got = 1'b1;
        end
        check("gnt_seen", 512'(got), 512'(1));
        check("gnt_vec", 512'(req_gnt), 512'(NR'(1) << r));
        req_valid[r] = 1'b0;
        if (!got) return;
        cyc = 0; done = 1'b0; saw_we = 1'b0; saw_re = 1'b0; dly = 0;
        while (!done && cyc < 200) begin
            @(negedge clk); cyc++;
            mem_complete_r = 1'b0;
            mem_complete_w = 1'b0;
            if (req_done != '0) begin
                done = 1'b1;
            end else if (mem_we) begin
                if (!saw_we) begin
                    saw_we = 1'b1;
                    check("wb_addr", 512'(mem_addr), 512'(e_wba));
                    check("wb_data", mem_wd, e_wbd);
                    dly = int'($urandom_range(0, 3));
                end
                if (dly == 0) mem_complete_w = 1'b1;
                else dly--;
            end else if (mem_re) begin
                if (!saw_re) begin
                    saw_re = 1'b1;
                    check("refill_addr", 512'(mem_addr), 512'(addr[27:2]));
                    dly = int'($urandom_range(0, 3));
                end
                if (dly == 0) begin
                    mem_rd = mem_line(addr[27:2]);
                    mem_complete_r = 1'b1;
                end else dly--;
            end
        end
        mem_complete_r = 1'b0;
        mem_complete_w = 1'b0;
        check("done_seen", 512'(done), 512'(1));
        check("done_vec", 512'(req_done), 512'(NR'(1) << r));
        check("busy_idle", 512'(busy), 512'(0));
        if (!rw) begin
            check("rdata", 512'(rdata), 512'(e_rd));
            last_rd = e_rd;
        end else begin
            check("rdata_hold", 512'(rdata), 512'(last_rd));
        end
        if (e_hit) check("hit_latency", 512'(cyc), 512'(2));
        check("wb_seen", 512'(saw_we), 512'(e_wb));
        check("refill_seen", 512'(saw_re), 512'(!e_hit));
        check("hit_cnt", 512'(hit_cnt), 512'(m_hits));
        check("miss_cnt", 512'(miss_cnt), 512'(m_miss));
    endtask

    // Both requesters contend continuously on cached lines.
    task automatic rr_test();
        logic [27:0]  a0, a1;
        logic [127:0] e_rd [2];
        logic [127:0] t_rd;
        bit           e_hit, e_wb;
        logic [25:0]  e_wba;
        logic [511:0] e_wbd;
        int           ng [2];
        int           grants, dones, cyc, w;
        logic [1:0]   prev_gnt;
        a0 = {17'd9, 9'd7, 2'd1};
        a1 = {17'd9, 9'd8, 2'd2};
        txn(0, 1'b0, a0, '0);
        txn(1, 1'b0, a1, '0);
        @(negedge clk);
        req_rw = '0;
        req_addr[0 +: AW]  = a0;
        req_addr[AW +: AW] = a1;
        req_valid = 2'b11;
        grants = 0; dones = 0; cyc = 0; prev_gnt = '0;
        ng[0] = 0; ng[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
        while (dones < 4 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (req_gnt != '0) begin
                check("rr_onehot", 512'($countones(req_gnt)), 512'(1));
                check("rr_width", 512'(prev_gnt), 512'(0));
                w = req_gnt[1] ? 1 : 0;
                check("rr_order", 512'(w), 512'(grants % 2));
                model_access(w == 1 ? a1 : a0, 1'b0, '0, e_hit, e_wb, e_wba, e_wbd, t_rd);
                e_rd[w] = t_rd;
                req_valid[w] = 1'b0;
                ng[w]++;
                grants++;
            end
            if (req_done != '0) begin
                w = req_done[1] ? 1 : 0;
                check("rr_rdata", 512'(rdata), 512'(e_rd[w]));
                last_rd = e_rd[w];
                if (ng[w] < 2) req_valid[w] = 1'b1;
                dones++;
            end
            if (mem_re || mem_we) check("rr_no_mem", 512'({mem_re, mem_we}), 512'(0));
            prev_gnt = req_gnt;
        end
        req_valid = '0;
        check("rr_done_cnt", 512'(dones), 512'(4));
        check("rr_hit_cnt", 512'(hit_cnt), 512'(m_hits));
        check("rr_miss_cnt", 512'(miss_cnt), 512'(m_miss));
    endtask

    // Reset arriving while a refill is outstanding.
    task automatic reset_mid_refill();
        int cyc;
        bit got;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_rw[1]    = 1'b0;
        req_addr[AW +: AW] = {17'd20, 9'd40, 2'd0};
        got = 1'b0; cyc = 0;
        while (!got && cyc < 50) begin
            @(negedge clk); cyc++;
            if (req_gnt != '0) got = 1'b1;
        end
        req_valid[1] = 1'b0;
        cyc = 0;
        while (!mem_re && cyc < 20) begin @(negedge clk); cyc++; end
        check("rst_refill_reached", 512'(mem_re), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mem_re", 512'(mem_re), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_mem_addr", 512'(mem_addr), 512'(0));
        check("rst_hit_cnt", 512'(hit_cnt), 512'(0));
        check("rst_miss_cnt", 512'(miss_cnt), 512'(0));
        check("rst_rdata", 512'(rdata), 512'(0));
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_done", 512'({req_done, busy}), 512'(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        mem_rd = '0; mem_complete_r = 1'b0; mem_complete_w = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outs", 512'({req_gnt, req_done, busy, mem_re, mem_we}), 512'(0));
        check("reset_rdata", 512'(rdata), 512'(0));
        check("reset_mem", 512'({mem_addr, mem_wd}), 512'(0));
        check("reset_cnts", 512'({hit_cnt, miss_cnt}), 512'(0));
        rst = 1'b0;

        // Cold miss, then hit on another word of the same line.
        txn(0, 1'b0, 28'h0000123, '0);
        txn(0, 1'b0, 28'h0000121, '0);

        // Stray completion pulses while idle must be ignored.
        @(negedge clk);
        mem_complete_r = 1'b1; mem_complete_w = 1'b1;
        @(negedge clk);
        mem_complete_r = 1'b0; mem_complete_w = 1'b0;
        @(negedge clk);
        check("stray_idle", 512'({busy, mem_re, mem_we, req_done}), 512'(0));

        // Dirty eviction from set 0.
        txn(0, 1'b1, 28'h0000800, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
        txn(0, 1'b0, 28'h0001000, '0);
        txn(0, 1'b0, 28'h0001800, '0);
        txn(0, 1'b0, 28'h0002000, '0);
        txn(0, 1'b0, 28'h0002800, '0);

        // PLRU: fill set 5 dirty, re-hit way 0, then force an eviction.
        for (int t = 1; t <= 4; t++)
            txn(0, 1'b1, {17'(t), 9'd5, 2'd0}, {4{32'(t)}});
        txn(0, 1'b0, {17'd1, 9'd5, 2'd3}, '0);
        txn(0, 1'b0, {17'd5, 9'd5, 2'd2}, '0);

        rr_test();

        reset_mid_refill();
        txn(0, 1'b0, 28'h0000123, '0);

        for (int i = 0; i < 200; i++)
            txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {17'($urandom_range(0, 5)), 9'($urandom_range(0, 2)), 2'($urandom_range(0, 3))},
                {$urandom, $urandom, $urandom, $urandom});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
